// File: rtl/rx_deserializer_pkg.sv
// Shared serial-receive definitions: frame size, default oversampling ratio
// and the deserializer state encoding.
package rx_deserializer_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_SAMPLE_RATIO = 16;

    typedef enum logic {
        COLLECT   = 1'b0,
        STOP_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/rx_deserializer_if.sv
// Signal bundle between the serial line/sampler side, the deserializer and
// the byte consumer.
interface rx_deserializer_if;

    logic       din;
    logic       sample_sig;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport slave (
        input  din, sample_sig, data_ready,
        output data_out, data_valid, frame_err, overrun, busy
    );

    modport master (
        output din, sample_sig, data_ready,
        input  data_out, data_valid, frame_err, overrun, busy
    );

endinterface

// File: rtl/rx_holding_reg.sv
// One-entry output register: commit/accept arbitration, valid flag and
// overrun pulse when an unread byte is replaced.
module rx_holding_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_commit,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_overrun
);

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // A commit wins over an accept; it only counts as an overrun
            // when the byte being replaced was not taken this same cycle.
            r_overrun <= i_commit & r_valid & ~i_ready;
            if (i_commit) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/rx_deserializer.sv
// Serial receive stage: shifts sampler-strobed data bits LSB-first, times and
// checks the stop bit, and hands good bytes to the holding register.
module rx_deserializer
    import rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_RATIO = DEFAULT_SAMPLE_RATIO
) (
    input  logic             sample_clk,
    input  logic             reset,
    rx_deserializer_if.slave bus
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [3:0] WAIT_LAST = 4'(SAMPLE_RATIO - 1);

    state_t     r_state,    w_state_nxt;
    logic [2:0] r_bit_cnt,  w_bit_cnt_nxt;
    logic [3:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [7:0] r_shreg,    w_shreg_nxt;
    logic       r_frame_err;
    logic       w_stop_sample;
    logic       w_commit;

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_frame_err <= w_stop_sample & ~bus.din;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_shreg_nxt    = r_shreg;
        w_stop_sample  = 1'b0;
        unique case (r_state)
            COLLECT: begin
                if (bus.sample_sig) begin
                    w_shreg_nxt = {bus.din, r_shreg[7:1]};
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_nxt  = '0;
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = STOP_WAIT;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            STOP_WAIT: begin
                // Strobes here are stray and deliberately ignored.
                if (r_wait_cnt == WAIT_LAST) begin
                    w_stop_sample  = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = COLLECT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                end
            end
        endcase
    end

    assign w_commit = w_stop_sample & bus.din;

    rx_holding_reg u_hold (
        .clk       (sample_clk),
        .reset     (reset),
        .i_commit  (w_commit),
        .i_data    (r_shreg),
        .i_ready   (bus.data_ready),
        .o_data    (bus.data_out),
        .o_valid   (bus.data_valid),
        .o_overrun (bus.overrun)
    );

    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_bit_cnt != '0) || (r_state == STOP_WAIT);

endmodule

// File: tb/tb_rx_deserializer.sv
// Scenario bench for rx_deserializer: drives 16x-oversampled frames with
// mid-bit strobes and checks committed bytes against a scoreboard queue.
module tb_rx_deserializer;

    logic sample_clk = 1'b0;
    logic reset      = 1'b1;
    int   n_checks   = 0;
    int   n_fail     = 0;
    logic [7:0] sb_q[$];

    rx_deserializer_if bus ();

    rx_deserializer #(.SAMPLE_RATIO(16)) dut (
        .sample_clk (sample_clk),
        .reset      (reset),
        .bus        (bus.slave)
    );

    always #5 sample_clk = ~sample_clk;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge sample_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v, input bit data_bit, input bit extra, input int unsigned ncyc);
        bus.din = v;
        for (int unsigned c = 0; c < ncyc; c++) begin
            bus.sample_sig = (data_bit && c == 7) || (extra && c == 3);
            tick(1);
        end
        bus.sample_sig = 1'b0;
    endtask

    // Drives a frame up to, but not including, the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit extra);
        send_bit(1'b0, 1'b0, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b1, 1'b0, 16);
        if (stop) sb_q.push_back(b);
        send_bit(stop, 1'b0, extra, 7);
    endtask

    task automatic finish_stop();
        bus.din = 1'b1;
        tick(10);
    endtask

    function automatic logic [7:0] sb_pop();
        if (sb_q.size() == 0) return 8'hxx;
        return sb_q.pop_front();
    endfunction

    task automatic consume();
        bus.data_ready = 1'b1;
        tick(1);
        bus.data_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.din = 1'b1; bus.sample_sig = 1'b0; bus.data_ready = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        n_checks++;
        if ({bus.data_out, bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h v=%b fe=%b ov=%b busy=%b required all 0",
                     bus.data_out, bus.data_valid, bus.frame_err, bus.overrun, bus.busy);
        end
        tick(2);
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        send_frame(8'hA5, 1'b1, 1'b0);
        n_checks++;
        if (bus.data_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pre_commit: got v=%b busy=%b required v=0 busy=1", bus.data_valid, bus.busy);
        end
        tick(1);
        exp = sb_pop();
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
            n_fail++;
            $display("FAIL basic_commit: got v=%b dout=%h required v=1 dout=%h", bus.data_valid, bus.data_out, exp);
        end
        n_checks++;
        if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_err: got fe=%b ov=%b required 0 0", bus.frame_err, bus.overrun);
        end
        finish_stop();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_busy: got %b required 0", bus.busy);
        end
        consume();
        n_checks++;
        if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_consumed: got v=%b dout=%h required v=0 dout=a5", bus.data_valid, bus.data_out);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] exp;
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(1);
        n_checks++;
        if (bus.frame_err !== 1'b1 || bus.data_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_pulse: got fe=%b v=%b ov=%b required fe=1 v=0 ov=0",
                     bus.frame_err, bus.data_valid, bus.overrun);
        end
        tick(1);
        n_checks++;
        if (bus.frame_err !== 1'b0 || bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_one_cycle: got fe=%b v=%b required fe=0 v=0", bus.frame_err, bus.data_valid);
        end
        finish_stop();
        send_frame(8'h81, 1'b1, 1'b0);
        tick(1);
        exp = sb_pop();
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp || bus.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_recover: got v=%b dout=%h fe=%b required v=1 dout=%h fe=0",
                     bus.data_valid, bus.data_out, bus.frame_err, exp);
        end
        finish_stop();
        consume();
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        send_frame(8'h11, 1'b1, 1'b0);
        tick(1);
        exp = sb_pop();
        n_checks++;
        if (bus.data_out !== exp || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first: got dout=%h ov=%b required dout=%h ov=0", bus.data_out, bus.overrun, exp);
        end
        finish_stop();
        send_frame(8'h22, 1'b1, 1'b0);
        tick(1);
        exp = sb_pop();
        n_checks++;
        if (bus.overrun !== 1'b1 || bus.frame_err !== 1'b0 || bus.data_out !== exp || bus.data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got ov=%b fe=%b dout=%h v=%b required ov=1 fe=0 dout=%h v=1",
                     bus.overrun, bus.frame_err, bus.data_out, bus.data_valid, exp);
        end
        tick(1);
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_one_cycle: got %b required 0", bus.overrun);
        end
        finish_stop();
        consume();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        send_frame(8'h11, 1'b1, 1'b0);
        tick(1);
        exp = sb_pop();
        n_checks++;
        if (bus.data_out !== exp || bus.data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got dout=%h v=%b required dout=%h v=1", bus.data_out, bus.data_valid, exp);
        end
        finish_stop();
        send_frame(8'h22, 1'b1, 1'b0);
        bus.data_ready = 1'b1;
        tick(1);
        bus.data_ready = 1'b0;
        exp = sb_pop();
        n_checks++;
        if (bus.overrun !== 1'b0 || bus.data_out !== exp || bus.data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_commit: got ov=%b dout=%h v=%b required ov=0 dout=%h v=1",
                     bus.overrun, bus.data_out, bus.data_valid, exp);
        end
        tick(1);
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold: got v=%b ov=%b required v=1 ov=0", bus.data_valid, bus.overrun);
        end
        finish_stop();
        consume();
    endtask

    task automatic test_stop_wait_pulse();
        logic [7:0] exp;
        send_frame(8'hF0, 1'b1, 1'b1);
        tick(1);
        exp = sb_pop();
        n_checks++;
        if (bus.data_out !== exp || bus.data_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_pulse: got dout=%h v=%b fe=%b required dout=%h v=1 fe=0",
                     bus.data_out, bus.data_valid, bus.frame_err, exp);
        end
        finish_stop();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp;
        logic [7:0] partial;
        partial = 8'hC3;
        send_bit(1'b0, 1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(partial[i], 1'b1, 1'b0, 16);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state: got busy=%b v=%b dout=%h required busy=0 v=0 dout=00",
                     bus.busy, bus.data_valid, bus.data_out);
        end
        bus.din = 1'b1;
        tick(20);
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(1);
        exp = sb_pop();
        n_checks++;
        if (bus.data_out !== exp || bus.data_valid !== 1'b1 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_frame: got dout=%h v=%b fe=%b ov=%b required dout=%h v=1 fe=0 ov=0",
                     bus.data_out, bus.data_valid, bus.frame_err, bus.overrun, exp);
        end
        finish_stop();
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_stop_wait_pulse();
        test_reset_midframe();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
